// File: rtl/vga_fb_arbiter_pkg.sv
// vga_fb_pkg: framebuffer geometry, pixel latency and arbiter enums
package vga_fb_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int PIX_LAT = 3;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {SLOT_VIDEO, SLOT_HOST} slot_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: host write request/grant bus
interface vga_fb_arbiter_if #(parameter int ADDR_W = 17, parameter int DATA_W = 8);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  modport master(output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave(input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/vga_fb_arbiter_addr_gen.sv
// vga_fb_addr_gen: maps 640x480 row/col to a 2x-scaled framebuffer word address
module vga_fb_addr_gen #(
  parameter int FB_W   = 320,
  parameter int ADDR_W = 17
) (
  input  logic [8:0]        row,
  input  logic [9:0]        col,
  output logic [ADDR_W-1:0] addr
);
  assign addr = ADDR_W'((32'(row) >> 1) * FB_W + (32'(col) >> 1));
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one pixel RAM between VGA scan-out, host writes and a frame clear.
// Optional VGA_FB_STALL_CNT_EN adds a saturating count of stalled host requests.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int FB_W   = vga_fb_pkg::FB_W,
  parameter int FB_H   = vga_fb_pkg::FB_H,
  parameter int ADDR_W = vga_fb_pkg::ADDR_W,
  parameter int DATA_W = vga_fb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        vga_row,
  input  logic [9:0]        vga_col,
  input  logic              vga_display,
  vga_fb_arbiter_if.slave   host,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_display
`ifdef VGA_FB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int WORDS = FB_W * FB_H;
  state_t state, state_nx;
  slot_t slot;
  logic [ADDR_W-1:0] cnt, vaddr, addr_nx;
  logic [DATA_W-1:0] fill, wdata_nx;
  logic we_nx, last, start;
  logic [1:0] vid_d;
  logic [PIX_LAT-1:0] disp_d;
  vga_fb_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_addr (.row(vga_row), .col(vga_col), .addr(vaddr));
  assign slot = (vga_display && !vga_col[0]) ? SLOT_VIDEO : SLOT_HOST;
  assign start = state == IDLE && clr_start;
  assign last = cnt == ADDR_W'(WORDS - 1);
  assign host.wr_ack = !rst && host.wr_req && slot == SLOT_HOST && state == IDLE && !clr_start;
  assign busy = state == CLEAR;
  assign pix_display = disp_d[PIX_LAT-1];
  always_comb begin
    state_nx = start ? CLEAR : (state == CLEAR && slot == SLOT_HOST && last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    we_nx = 1'b0;
    addr_nx = mem_addr;
    wdata_nx = mem_wdata;
    if (slot == SLOT_VIDEO) begin
      addr_nx = vaddr;
    end else if (state == CLEAR) begin
      we_nx = 1'b1;
      addr_nx = cnt;
      wdata_nx = fill;
    end else if (host.wr_ack && 32'(host.wr_addr) < WORDS) begin
      we_nx = 1'b1;
      addr_nx = host.wr_addr;
      wdata_nx = host.wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fill <= '0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      pix_data <= '0;
      vid_d <= '0;
      disp_d <= '0;
    end else begin
      cnt <= start ? '0 : (state == CLEAR && slot == SLOT_HOST) ? cnt + 1'b1 : cnt;
      fill <= start ? clr_data : fill;
      mem_addr <= addr_nx;
      mem_we <= we_nx;
      mem_wdata <= wdata_nx;
      vid_d <= {vid_d[0], slot == SLOT_VIDEO};
      disp_d <= {disp_d[PIX_LAT-2:0], vga_display};
      // read data lands two cycles after the video slot; odd columns reuse it
      pix_data <= !disp_d[PIX_LAT-2] ? '0 : vid_d[1] ? mem_rdata : pix_data;
    end
  end
`ifdef VGA_FB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (host.wr_req && !host.wr_ack && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule
